float_mul_pipe: RTL and testbench

FLOAT_MUL_PIPE -- requirements
Module: float_mul_pipe

---
 rtl/float_mul_pipe.sv | 127 ++++++++++++
 tb/tb_float_mul_pipe.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/float_mul_pipe.sv
// Three-stage pipelined floating-point multiplier (no denormals, truncating).
// Stages: S1 captures operands, S2 forms exponent sum and mantissa product, S3 normalizes and packs.
module float_mul_pipe #(
  parameter int WIDTH     = 32,
  parameter int WIDTH_exp = 8,
  parameter int WIDTH_mat = 23
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [WIDTH-1:0] OP1,
  input  logic [WIDTH-1:0] OP2,
  input  logic             exce_in,
  output logic [WIDTH-1:0] result,
  output logic             exce_out
);

  localparam int MW   = WIDTH_mat + 1;
  localparam int PW   = 2 * MW;
  localparam int EW   = WIDTH_exp + 2;
  localparam int BIAS = 2 ** (WIDTH_exp - 1) - 1;
  localparam int EMAX = 2 ** WIDTH_exp - 1;

  localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS);
  localparam logic signed [EW-1:0] EMAX_S = EW'(EMAX);

  // S1 registers
  logic [WIDTH-1:0] op1_q, op2_q;
  logic             exc1_q;

  // S2 registers
  logic                 sign2_q;
  logic signed [EW-1:0] exp2_q;
  logic [PW-1:0]        prod2_q;
  logic                 zero2_q;
  logic                 spec2_q;
  logic                 exc2_q;

  // S3 (output) registers
  logic [WIDTH-1:0] result_q;
  logic             exce_q;

  // S2 next-state
  logic [WIDTH_exp-1:0] exp_a, exp_b;
  logic [WIDTH_mat-1:0] frac_a, frac_b;
  logic                 sign2_d, zero2_d, spec2_d;
  logic signed [EW-1:0] exp2_d;
  logic [PW-1:0]        prod2_d;

  always_comb begin
    exp_a   = op1_q[WIDTH-2 -: WIDTH_exp];
    exp_b   = op2_q[WIDTH-2 -: WIDTH_exp];
    frac_a  = op1_q[WIDTH_mat-1:0];
    frac_b  = op2_q[WIDTH_mat-1:0];
    sign2_d = op1_q[WIDTH-1] ^ op2_q[WIDTH-1];
    zero2_d = (exp_a == '0) || (exp_b == '0);
    spec2_d = (&exp_a) || (&exp_b);
    exp2_d  = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS_S;
    prod2_d = PW'({1'b1, frac_a}) * PW'({1'b1, frac_b});
  end

  // S3 next-state: normalize, classify, pack
  logic                 norm;
  logic signed [EW-1:0] exp_n;
  logic [WIDTH_mat-1:0] frac_n;
  logic                 ovf, unf;
  logic [WIDTH-1:0]     result_d;
  logic                 exce_d;
  logic                 unused_lsb;

  assign unused_lsb = ^prod2_q[PW-WIDTH_mat-3:0];

  always_comb begin
    norm   = prod2_q[PW-1];
    frac_n = norm ? prod2_q[PW-2 -: WIDTH_mat] : prod2_q[PW-3 -: WIDTH_mat];
    exp_n  = exp2_q + $signed({{(EW-1){1'b0}}, norm});
    ovf    = (exp_n >= EMAX_S);
    unf    = exp_n[EW-1] || (exp_n == '0);
    result_d = {sign2_q, exp_n[WIDTH_exp-1:0], frac_n};
    exce_d   = exc2_q;
    // Inf/NaN operands win over a zero operand so the exception is never lost
    if (spec2_q) begin
      result_d = {sign2_q, {WIDTH_exp{1'b1}}, {WIDTH_mat{1'b0}}};
      exce_d   = 1'b1;
    end else if (zero2_q) begin
      result_d = {sign2_q, {(WIDTH-1){1'b0}}};
      exce_d   = exc2_q;
    end else if (ovf) begin
      result_d = {sign2_q, {WIDTH_exp{1'b1}}, {WIDTH_mat{1'b0}}};
      exce_d   = 1'b1;
    end else if (unf) begin
      result_d = {sign2_q, {(WIDTH-1){1'b0}}};
      exce_d   = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      op1_q    <= '0;
      op2_q    <= '0;
      exc1_q   <= 1'b0;
      sign2_q  <= 1'b0;
      exp2_q   <= '0;
      prod2_q  <= '0;
      zero2_q  <= 1'b0;
      spec2_q  <= 1'b0;
      exc2_q   <= 1'b0;
      result_q <= '0;
      exce_q   <= 1'b0;
    end else begin
      op1_q    <= OP1;
      op2_q    <= OP2;
      exc1_q   <= exce_in;
      sign2_q  <= sign2_d;
      exp2_q   <= exp2_d;
      prod2_q  <= prod2_d;
      zero2_q  <= zero2_d;
      spec2_q  <= spec2_d;
      exc2_q   <= exc1_q;
      result_q <= result_d;
      exce_q   <= exce_d;
    end
  end

  assign result   = result_q;
  assign exce_out = exce_q;

endmodule

// File: tb/tb_float_mul_pipe.sv
// Bench for float_mul_pipe: directed vectors, expected results queued at issue time
// and checked by an independent monitor when each result is due.
module tb_float_mul_pipe;

  localparam int W = 32;

  logic         CLK;
  logic         nRST;
  logic [W-1:0] OP1, OP2;
  logic         exce_in;
  logic [W-1:0] result;
  logic         exce_out;

  float_mul_pipe #(.WIDTH(32), .WIDTH_exp(8), .WIDTH_mat(23)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .OP1      (OP1),
    .OP2      (OP2),
    .exce_in  (exce_in),
    .result   (result),
    .exce_out (exce_out)
  );

  // clock/reset block
  int cyc = 0;
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  logic         exc_q[$];
  int           due_q[$];
  string        name_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic flush_sb();
    exp_q.delete();
    exc_q.delete();
    due_q.delete();
    name_q.delete();
  endtask

  // driver: apply one operation and queue its expected response
  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic e,
                          input logic [W-1:0] er, input logic ee, input string name);
    @(negedge CLK);
    OP1     = a;
    OP2     = b;
    exce_in = e;
    exp_q.push_back(er);
    exc_q.push_back(ee);
    due_q.push_back(cyc + 3);
    name_q.push_back(name);
  endtask

  // monitor
  always @(posedge CLK) begin
    #1;
    if (nRST) begin
      while (due_q.size() > 0 && due_q[0] <= cyc) begin
        if (due_q[0] < cyc) begin
          n_tests++;
          n_fail++;
          $display("FAIL %s: result never sampled at cycle %0d (now %0d)", name_q[0], due_q[0], cyc);
        end else begin
          check({name_q[0], "_result"}, result, exp_q[0]);
          check({name_q[0], "_exce"}, {31'b0, exce_out}, {31'b0, exc_q[0]});
        end
        void'(exp_q.pop_front());
        void'(exc_q.pop_front());
        void'(due_q.pop_front());
        void'(name_q.pop_front());
      end
    end
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         e;
    logic [W-1:0] r;
    logic         x;
  } vec_t;

  vec_t vecs[20];

  initial begin
    vecs = '{
      '{32'h3E000078, 32'h3F700000, 1'b0, 32'h3DF000E1, 1'b0},
      '{32'h3F600000, 32'h3F700000, 1'b0, 32'h3F520000, 1'b0},
      '{32'h41E00000, 32'h41E00000, 1'b0, 32'h44440000, 1'b0},
      '{32'h43E00000, 32'h41E00000, 1'b1, 32'h46440000, 1'b1},
      '{32'hC3E00000, 32'h41E00000, 1'b0, 32'hC6440000, 1'b0},
      '{32'h47E00000, 32'h47E00000, 1'b0, 32'h50440000, 1'b0},
      '{32'hC7E00000, 32'h4FE00000, 1'b0, 32'hD8440000, 1'b0},
      '{32'h71800000, 32'h71800000, 1'b0, 32'h7F800000, 1'b1},
      '{32'h00000000, 32'h41E00000, 1'b0, 32'h00000000, 1'b0},
      '{32'h80000000, 32'h41E00000, 1'b1, 32'h80000000, 1'b1},
      '{32'h00800000, 32'h00800000, 1'b0, 32'h00000000, 1'b1},
      '{32'h80800000, 32'h00800000, 1'b0, 32'h80000000, 1'b1},
      '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 1'b1},
      '{32'hFFC00000, 32'h3F800000, 1'b0, 32'hFF800000, 1'b1},
      '{32'h7F000000, 32'h3F800000, 1'b0, 32'h7F000000, 1'b0},
      '{32'h7F400000, 32'h3FC00000, 1'b0, 32'h7F800000, 1'b1},
      '{32'h00800000, 32'h3F800000, 1'b0, 32'h00800000, 1'b0},
      '{32'h00800000, 32'h3F000000, 1'b0, 32'h00000000, 1'b1},
      '{32'h3F800000, 32'hBF800000, 1'b0, 32'hBF800000, 1'b0},
      '{32'h40000000, 32'h40400000, 1'b1, 32'h40C00000, 1'b1}
    };

    nRST    = 1'b0;
    OP1     = 32'h3F800000;
    OP2     = 32'h3F800000;
    exce_in = 1'b1;
    #1;
    check("reset_result", result, '0);
    check("reset_exce", {31'b0, exce_out}, '0);
    repeat (3) @(posedge CLK);
    #1;
    check("reset_hold_result", result, '0);
    check("reset_hold_exce", {31'b0, exce_out}, '0);

    @(negedge CLK);
    OP1     = '0;
    OP2     = '0;
    exce_in = 1'b0;
    nRST    = 1'b1;

    foreach (vecs[i])
      drive_op(vecs[i].a, vecs[i].b, vecs[i].e, vecs[i].r, vecs[i].x, $sformatf("vec%0d", i));

    // keep the pipeline full of non-zero work, then reset between edges
    drive_op(32'h41E00000, 32'h41E00000, 1'b1, 32'h44440000, 1'b1, "pre_rst0");
    drive_op(32'h43E00000, 32'h41E00000, 1'b1, 32'h46440000, 1'b1, "pre_rst1");
    drive_op(32'h47E00000, 32'h47E00000, 1'b1, 32'h50440000, 1'b1, "pre_rst2");
    drive_op(32'h3F600000, 32'h3F700000, 1'b1, 32'h3F520000, 1'b1, "pre_rst3");
    @(posedge CLK);
    #3;
    nRST = 1'b0;
    #1;
    check("midrst_result", result, '0);
    check("midrst_exce", {31'b0, exce_out}, '0);
    flush_sb();
    @(negedge CLK);
    OP1     = '0;
    OP2     = '0;
    exce_in = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;

    for (int k = 0; k < 5; k++)
      drive_op('0, '0, 1'b0, '0, 1'b0, $sformatf("post_rst_idle%0d", k));
    drive_op(32'h3E000078, 32'h3F700000, 1'b0, 32'h3DF000E1, 1'b0, "post_rst_op");
    drive_op('0, '0, 1'b0, '0, 1'b0, "post_rst_tail");

    for (int k = 0; k < 10 && due_q.size() > 0; k++) @(negedge CLK);
    if (due_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", due_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
